// File: rtl/eight_bit_exp_decay_lut.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_exp_decay_lut
// Description : 256-entry exponential decay ROM, LUT[i] = round(255*2^(-i/32)),
//               registered output. Optional macro EXP_LUT_ZERO_TAIL_EN forces
//               entry 255 to zero so a full release ends at silence.
// Revision    : 1.0 - initial release
// ============================================================================
module eight_bit_exp_decay_lut (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  output logic [7:0] dout
);

`ifdef EXP_LUT_ZERO_TAIL_EN
  localparam logic C_ZERO_TAIL = 1'b1;
`else
  localparam logic C_ZERO_TAIL = 1'b0;
`endif

  // b^32 by five squarings; wide enough to hold 509^32 shifted left by 255.
  function automatic logic [575:0] pow32(input logic [8:0] b);
    logic [575:0] p;
    p = {567'd0, b};
    for (int k = 0; k < 5; k++) begin
      p = p * p;
    end
    return p;
  endfunction

  // round(255*2^(-i/32)) is the largest v with (v-0.5) <= 255*2^(-i/32),
  // i.e. (2v-1)^32 * 2^i <= 510^32, which is exact in integer arithmetic.
  function automatic logic [7:0] lut_entry(input int idx);
    logic [575:0] lim;
    logic [8:0]   lo;
    logic [8:0]   hi;
    logic [8:0]   mid;
    lim = pow32(9'd510);
    lo  = 9'd0;
    hi  = 9'd255;
    for (int k = 0; k < 8; k++) begin
      mid = (lo + hi + 9'd1) >> 1;
      if (lo < hi) begin
        if ((pow32({mid[7:0], 1'b0} - 9'd1) << idx) <= lim) begin
          lo = mid;
        end else begin
          hi = mid - 9'd1;
        end
      end
    end
    return lo[7:0];
  endfunction

  logic [7:0] rom [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    localparam logic [7:0] C_VAL = (C_ZERO_TAIL && (gi == 255)) ? 8'h00 : lut_entry(gi);
    assign rom[gi] = C_VAL;
  end

  logic [7:0] dout_d;
  logic [7:0] dout_q;

  always_comb begin
    dout_d = rom[din];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_exp_decay_lut.sv
`default_nettype none
// Bench for eight_bit_exp_decay_lut: floating-point reference of the decay curve,
// per-cycle model comparison plus literal key-point checks.
module tb_eight_bit_exp_decay_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] dout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  eight_bit_exp_decay_lut dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  function automatic int ref_lut(input int i);
    real x;
`ifdef EXP_LUT_ZERO_TAIL_EN
    if (i == 255) return 0;
`endif
    x = 255.0 * $pow(2.0, -real'(i) / 32.0);
    return int'($floor(x + 0.5));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: whatever the DUT sampled at the last rising edge.
  int exp_q     = 0;
  bit exp_valid = 1'b0;
  always @(posedge clk) begin
    exp_q     <= rst ? 0 : ref_lut(int'(din));
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) check("model", int'(dout), exp_q);
  end

  task automatic step(input logic r, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    din = d;
  endtask

  int key_idx [10] = '{0, 1, 16, 32, 64, 96, 128, 160, 192, 224};
  int key_val [10] = '{255, 250, 180, 128, 64, 32, 16, 8, 4, 2};
  int tail_val;
  int prev;

  initial begin
`ifdef EXP_LUT_ZERO_TAIL_EN
    tail_val = 0;
`else
    tail_val = 1;
`endif
    rst = 1'b1;
    din = 8'h00;

    // Reset held for two edges
    @(negedge clk);
    check("reset_edge1", int'(dout), 0);
    @(negedge clk);
    check("reset_edge2", int'(dout), 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset", int'(dout), 255);

    // Key points, pinned against literal values
    for (int k = 0; k < 10; k++) begin
      din = key_idx[k][7:0];
      @(negedge clk);
      check($sformatf("key_%0d", key_idx[k]), int'(dout), key_val[k]);
      check($sformatf("model_pin_%0d", key_idx[k]), ref_lut(key_idx[k]), key_val[k]);
    end

    // Full sweep with monotonicity
    prev = 255;
    for (int i = 0; i < 256; i++) begin
      din = 8'(i);
      @(negedge clk);
      if (int'(dout) > prev) check($sformatf("monotonic_%0d", i), int'(dout), prev);
      prev = int'(dout);
    end
    check("sweep_monotonic_end", prev, tail_val);

    // Tail entry
    din = 8'hFF;
    @(negedge clk);
    check("tail", int'(dout), tail_val);

    // Back-to-back alternation
    for (int k = 0; k < 16; k++) begin
      din = (k % 2 == 0) ? 8'h00 : 8'hFF;
      @(negedge clk);
      check($sformatf("alt_%0d", k), int'(dout), (k % 2 == 0) ? 255 : tail_val);
    end

    // Reset for a single edge in the middle of a sweep
    for (int i = 90; i < 111; i++) begin
      din = 8'(i);
      rst = (i == 100);
      @(negedge clk);
      check($sformatf("midrst_%0d", i), int'(dout), (i == 100) ? 0 : ref_lut(i));
    end
    rst = 1'b0;

    // Random traffic, occasional reset; the model process does the checking
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
    end
    step(1'b0, 8'h00);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
